// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B - BIN computed LSB first over WIDTH cycles
// with one full-subtractor cell, a borrow flop and a START/BUSY/DONE handshake.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              r_q, r_d;
    logic              bout_q, bout_d;
    logic              done_q, done_d;

    // Full-subtractor cell on the current operand LSBs.
    logic d_bit;
    logic r_next;

    assign d_bit  = a_q[0] ^ b_q[0] ^ r_q;
    assign r_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & r_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        bout_d  = bout_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    r_d     = bin;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                diff_d = {d_bit, diff_q[WIDTH-1:1]};
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                r_d    = r_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    bout_d  = r_next;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            r_q     <= 1'b0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign busy = (state_q == StRun);
    assign done = done_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial subtractor. Computes DIFF = A - B - BIN over WIDTH clock cycles, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the inverse-operation companion to the combinational ripple adder, and trades latency for area. It is used wherever the parallel adder's carry chain is too large, with a START/BUSY/DONE handshake toward the controlling logic.

Parameters:
WIDTH, 4, operand and result width in bits (WIDTH >= 2).

Ports:
CLK  input  1  system clock; all state changes on rising edge
RST_N  input  1  synchronous reset, active-low; sampled on rising edge of CLK
START  input  1  request; sampled only while BUSY=0
A  input  WIDTH  minuend; captured on the accepted START edge
B  input  WIDTH  subtrahend; captured on the accepted START edge
BIN  input  1  borrow-in; captured on the accepted START edge
DIFF  output  WIDTH  result; valid from DONE and held until the next accepted START
BOUT  output  1  borrow-out (1 = A < B + BIN, unsigned); same validity as DIFF
BUSY  output  1  high while an operation is in progress
DONE  output  1  one-cycle pulse marking result valid

Behaviour:
- Clocking: one clock (CLK). Reset is synchronous and active-low (RST_N); reset takes priority over all other inputs.
- Reset values:
  - DIFF=0, BOUT=0, BUSY=0, DONE=0.
  - FSM=IDLE.
  - Internal operand shift registers, borrow FF and bit counter are all cleared to 0.
- FSM has two states, IDLE and RUN.
- IDLE:
  - DONE is low except in the pulse cycle described under RUN.
  - START=1 at edge k: capture A, B and BIN (into the borrow FF), clear the counter, and enter RUN.
  - BUSY=1 from the cycle after edge k.
  - DIFF and BOUT keep their old values until overwritten.
- RUN:
  - Each edge processes bit i (counter = i) from the operand shift register LSBs a, b and borrow r.
  - d = a ^ b ^ r.
  - r_next = (~a & b) | (~(a ^ b) & r).
  - d is shifted into the MSB of the DIFF shift register; operands shift right by 1; counter increments.
- Completion: on the edge processing bit WIDTH-1 (edge k+WIDTH):
  - FSM returns to IDLE, BUSY goes to 0 and DONE goes to 1.
  - DIFF holds the full result and BOUT = r_next.
  - DONE stays high for exactly one cycle.
- Latency: START sampled at edge k → DONE=1 and result valid in the cycle after edge k+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- Back-to-back operation:
  - START=1 in the DONE cycle is accepted, because the FSM is already IDLE.
  - The new operation does not clear the previous DIFF until its first shift.
  - DIFF is only guaranteed valid in the DONE cycle and while idle afterwards.
- START while BUSY=1: ignored; operands are not re-captured and the operation in flight is unaffected.
- A, B and BIN may change freely after the capture edge.
- Arithmetic: unsigned, modulo 2^WIDTH.
  - {BOUT, DIFF} equals the (WIDTH+1)-bit two's-complement result of A - B - BIN.
  - Equivalently, DIFF = A + ~B + ~BIN (mod 2^WIDTH) and BOUT = ~carry-out.
- Reset mid-RUN (RST_N=0 at any edge): abort immediately to reset values; no DONE pulse.
- Counter is ceil(log2(WIDTH)) bits wide; no wrap occurs beyond WIDTH-1 because the FSM exits RUN first.

Test Plan:
- WIDTH=4, A=9, B=3, BIN=0, START 1 cycle → BUSY high 4 cycles, DONE one cycle after edge k+4, DIFF=6, BOUT=0.
- A=3, B=9, BIN=0 → DIFF=0xA, BOUT=1; A=0, B=0, BIN=1 → DIFF=0xF, BOUT=1; A=15, B=15, BIN=0 → DIFF=0, BOUT=0.
- Hold START=1 continuously with A=5, B=2 → DONE pulses every 5 cycles, DIFF=3 each time; change A to 7 mid-RUN → the in-flight result is still 3 and the next result is 5.
- Pulse START again 2 cycles into RUN with A=1, B=1 → ignored; result of the original operation is unchanged; no extra DONE.
- Assert RST_N=0 for one edge at bit 2 of A=12, B=5 → all outputs 0, BUSY=0, no DONE; a subsequent START gives DIFF=7, BOUT=0.
- Exhaustive run over all A, B in 0..15 and BIN in {0,1}, checked against the model (A - B - BIN) mod 32 → {BOUT, DIFF} matches for all 512 cases.
